// File: rtl/decode_stage_pipe_if.sv
// Fetch->decode and decode->execute channels; valid/ready, a beat moves when both are high.
// Parameters follow the decode stage (DATA_W, REG_AW).
interface decode_in_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_instr;
    logic [DATA_W-1:0] in_pc;
    logic [1:0]        ctl_regdst;
    logic              ctl_wen;
    logic              ctl_signext;

    modport master (
        output in_valid, in_instr, in_pc, ctl_regdst, ctl_wen, ctl_signext,
        input  in_ready
    );
    modport slave (
        input  in_valid, in_instr, in_pc, ctl_regdst, ctl_wen, ctl_signext,
        output in_ready
    );
endinterface

interface decode_out_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
);
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_instr;
    logic [DATA_W-1:0] out_pc;
    logic [DATA_W-1:0] out_rs_data;
    logic [DATA_W-1:0] out_rt_data;
    logic [DATA_W-1:0] out_imm5;
    logic [DATA_W-1:0] out_imm8;
    logic [DATA_W-1:0] out_imm11;
    logic [REG_AW-1:0] out_dst;
    logic              out_wen;

    modport master (
        output out_valid, out_instr, out_pc, out_rs_data, out_rt_data,
               out_imm5, out_imm8, out_imm11, out_dst, out_wen,
        input  out_ready
    );
    modport slave (
        input  out_valid, out_instr, out_pc, out_rs_data, out_rt_data,
               out_imm5, out_imm8, out_imm11, out_dst, out_wen,
        output out_ready
    );
endinterface

// File: rtl/decode_stage_pipe.sv
// Decode stage: regfile, dest select, immediate extension, ID/EX register; DECODE_BYPASS_EN adds wb forwarding.
// Latency 1 cycle from accept to out_valid; stalls on load-use (and wb read-after-write without bypass).
// Backpressure: ID/EX holds while out_valid & !out_ready; flush kills ID/EX and blocks accept that cycle.
module decode_stage_pipe #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    decode_in_if.slave        in_bus,
    decode_out_if.master      out_bus,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_sel,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_ld_pending,
    input  logic [REG_AW-1:0] ex_ld_reg,
    output logic [15:0]       stall_cnt
);

    localparam logic [REG_AW-1:0] LAST_REG = REG_AW'(NREG - 1);

    logic [DATA_W-1:0] regs [NREG];
    logic [REG_AW-1:0] rs_sel, rt_sel, rd_sel, dst_sel;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic [DATA_W-1:0] imm5, imm8, imm11;
    logic              wb_raw, ld_use, stall, accept;

    assign rs_sel = in_bus.in_instr[8 +: REG_AW];
    assign rt_sel = in_bus.in_instr[5 +: REG_AW];
    assign rd_sel = in_bus.in_instr[2 +: REG_AW];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[wb_sel] <= wb_data;
        end
    end

`ifdef DECODE_BYPASS_EN
    always_comb begin
        rs_val = (wb_en && (wb_sel == rs_sel)) ? wb_data : regs[rs_sel];
        rt_val = (wb_en && (wb_sel == rt_sel)) ? wb_data : regs[rt_sel];
        wb_raw = 1'b0;
    end
`else
    // Without forwarding a same-cycle writeback is seen one cycle later, so hold the instr.
    always_comb begin
        rs_val = regs[rs_sel];
        rt_val = regs[rt_sel];
        wb_raw = wb_en && ((wb_sel == rs_sel) || (wb_sel == rt_sel));
    end
`endif

    assign ld_use = ex_ld_pending && ((ex_ld_reg == rs_sel) || (ex_ld_reg == rt_sel));
    assign stall  = in_bus.in_valid && (ld_use || wb_raw);

    assign in_bus.in_ready = !stall && !flush && (!out_bus.out_valid || out_bus.out_ready);
    assign accept          = in_bus.in_valid && in_bus.in_ready;

    assign imm5  = {{(DATA_W-5){in_bus.ctl_signext & in_bus.in_instr[4]}},   in_bus.in_instr[4:0]};
    assign imm8  = {{(DATA_W-8){in_bus.ctl_signext & in_bus.in_instr[7]}},   in_bus.in_instr[7:0]};
    assign imm11 = {{(DATA_W-11){in_bus.ctl_signext & in_bus.in_instr[10]}}, in_bus.in_instr[10:0]};

    always_comb begin
        dst_sel = rd_sel;
        case (in_bus.ctl_regdst)
            2'd1:    dst_sel = rt_sel;
            2'd2:    dst_sel = rs_sel;
            2'd3:    dst_sel = LAST_REG;
            default: dst_sel = rd_sel;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_bus.out_valid   <= 1'b0;
            out_bus.out_instr   <= '0;
            out_bus.out_pc      <= '0;
            out_bus.out_rs_data <= '0;
            out_bus.out_rt_data <= '0;
            out_bus.out_imm5    <= '0;
            out_bus.out_imm8    <= '0;
            out_bus.out_imm11   <= '0;
            out_bus.out_dst     <= '0;
            out_bus.out_wen     <= 1'b0;
        end else if (flush) begin
            out_bus.out_valid <= 1'b0;
        end else if (accept) begin
            out_bus.out_valid   <= 1'b1;
            out_bus.out_instr   <= in_bus.in_instr;
            out_bus.out_pc      <= in_bus.in_pc;
            out_bus.out_rs_data <= rs_val;
            out_bus.out_rt_data <= rt_val;
            out_bus.out_imm5    <= imm5;
            out_bus.out_imm8    <= imm8;
            out_bus.out_imm11   <= imm11;
            out_bus.out_dst     <= dst_sel;
            out_bus.out_wen     <= in_bus.ctl_wen;
        end else if (out_bus.out_ready) begin
            // Drained with nothing new (idle or stalled): insert a bubble.
            out_bus.out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: vector table for decode fields plus hand sequences for
// writeback, hazards, backpressure, flush and mid-transfer reset.
module tb_decode_stage_pipe;
    localparam int DATA_W = 16;
    localparam int NREG   = 8;
    localparam int REG_AW = 3;
`ifdef DECODE_BYPASS_EN
    localparam logic [15:0] STALL0 = 16'd0;
`else
    localparam logic [15:0] STALL0 = 16'd1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              flush, wb_en, ex_ld_pending;
    logic [REG_AW-1:0] wb_sel, ex_ld_reg;
    logic [DATA_W-1:0] wb_data;
    logic [15:0]       stall_cnt;

    decode_in_if  #(.DATA_W(DATA_W))                  in_bus ();
    decode_out_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) out_bus ();

    decode_stage_pipe #(.DATA_W(DATA_W), .NREG(NREG), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst), .in_bus(in_bus), .out_bus(out_bus),
        .flush(flush), .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
        .ex_ld_pending(ex_ld_pending), .ex_ld_reg(ex_ld_reg), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] instr, input logic [15:0] pc,
                         input logic sx, input logic [1:0] rd, input logic wen);
        in_bus.in_valid    = v;
        in_bus.in_instr    = instr;
        in_bus.in_pc       = pc;
        in_bus.ctl_signext = sx;
        in_bus.ctl_regdst  = rd;
        in_bus.ctl_wen     = wen;
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic        sx;
        logic [1:0]  rd;
        logic        wen;
        logic [15:0] e_rs, e_rt, e_i5, e_i8, e_i11;
        logic [2:0]  e_dst;
    } vec_t;

    vec_t vecs [6];

    initial begin
        // regs hold 16'hA00i after preload
        vecs[0] = '{16'h0080, 16'h0100, 1'b1, 2'd3, 1'b1, 16'hA000, 16'hA004, 16'h0000, 16'hFF80, 16'h0080, 3'd7};
        vecs[1] = '{16'h0080, 16'h0101, 1'b0, 2'd0, 1'b0, 16'hA000, 16'hA004, 16'h0000, 16'h0080, 16'h0080, 3'd0};
        vecs[2] = '{16'h7FFF, 16'h0102, 1'b1, 2'd1, 1'b1, 16'hA007, 16'hA007, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'd7};
        vecs[3] = '{16'h7FFF, 16'h0103, 1'b0, 2'd2, 1'b0, 16'hA007, 16'hA007, 16'h001F, 16'h00FF, 16'h07FF, 3'd7};
        vecs[4] = '{16'h0A4C, 16'h0104, 1'b1, 2'd0, 1'b1, 16'hA002, 16'hA002, 16'h000C, 16'h004C, 16'h024C, 3'd3};
        vecs[5] = '{16'h0530, 16'h0105, 1'b1, 2'd2, 1'b0, 16'hA005, 16'hA001, 16'hFFF0, 16'h0030, 16'hFD30, 3'd5};

        rst = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_sel = '0; wb_data = '0;
        ex_ld_pending = 1'b0; ex_ld_reg = '0;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b0);
        out_bus.out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_bus.out_valid), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_in_ready",  32'(in_bus.in_ready), 32'd1);
        tick();
        rst = 1'b1;
        tick();

        // writeback then read of r3
        wb_en = 1'b1; wb_sel = 3'd3; wb_data = 16'h1234;
        tick();
        wb_en = 1'b0;
        drive(1'b1, 16'h0300, 16'h0040, 1'b0, 2'd0, 1'b0);
        #1;
        chk("wb_rd_in_ready", 32'(in_bus.in_ready), 32'd1);
        chk("wb_rd_pre_valid", 32'(out_bus.out_valid), 32'd0);
        tick();
        chk("wb_rd_valid", 32'(out_bus.out_valid), 32'd1);
        chk("wb_rd_rs", 32'(out_bus.out_rs_data), 32'h1234);
        chk("wb_rd_pc", 32'(out_bus.out_pc), 32'h0040);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b0);

        for (int i = 0; i < NREG; i++) begin
            wb_en = 1'b1; wb_sel = 3'(i); wb_data = 16'hA000 | 16'(i);
            tick();
        end
        wb_en = 1'b0;

        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].instr, vecs[i].pc, vecs[i].sx, vecs[i].rd, vecs[i].wen);
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_bus.in_ready), 32'd1);
            tick();
            chk($sformatf("v%0d_valid", i), 32'(out_bus.out_valid), 32'd1);
            chk($sformatf("v%0d_instr", i), 32'(out_bus.out_instr), 32'(vecs[i].instr));
            chk($sformatf("v%0d_pc", i),    32'(out_bus.out_pc),    32'(vecs[i].pc));
            chk($sformatf("v%0d_rs", i),    32'(out_bus.out_rs_data), 32'(vecs[i].e_rs));
            chk($sformatf("v%0d_rt", i),    32'(out_bus.out_rt_data), 32'(vecs[i].e_rt));
            chk($sformatf("v%0d_imm5", i),  32'(out_bus.out_imm5),  32'(vecs[i].e_i5));
            chk($sformatf("v%0d_imm8", i),  32'(out_bus.out_imm8),  32'(vecs[i].e_i8));
            chk($sformatf("v%0d_imm11", i), 32'(out_bus.out_imm11), 32'(vecs[i].e_i11));
            chk($sformatf("v%0d_dst", i),   32'(out_bus.out_dst),   32'(vecs[i].e_dst));
            chk($sformatf("v%0d_wen", i),   32'(out_bus.out_wen),   32'(vecs[i].wen));
        end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b0);
        tick();
        chk("drain_valid", 32'(out_bus.out_valid), 32'd0);

        // same-cycle writeback of r2 with rt=r2
        drive(1'b1, 16'h0040, 16'h0050, 1'b0, 2'd0, 1'b0);
        wb_en = 1'b1; wb_sel = 3'd2; wb_data = 16'hBEEF;
        #1;
`ifdef DECODE_BYPASS_EN
        chk("raw_in_ready", 32'(in_bus.in_ready), 32'd1);
        tick();
        wb_en = 1'b0;
        chk("raw_valid", 32'(out_bus.out_valid), 32'd1);
        chk("raw_rt", 32'(out_bus.out_rt_data), 32'hBEEF);
        chk("raw_stall_cnt", 32'(stall_cnt), 32'd0);
`else
        chk("raw_in_ready", 32'(in_bus.in_ready), 32'd0);
        tick();
        wb_en = 1'b0;
        chk("raw_bubble", 32'(out_bus.out_valid), 32'd0);
        chk("raw_stall_cnt", 32'(stall_cnt), 32'd1);
        #1;
        chk("raw_in_ready2", 32'(in_bus.in_ready), 32'd1);
        tick();
        chk("raw_valid", 32'(out_bus.out_valid), 32'd1);
        chk("raw_rt", 32'(out_bus.out_rt_data), 32'hBEEF);
        chk("raw_stall_cnt2", 32'(stall_cnt), 32'd1);
`endif
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b0);
        tick();

        // load-use on rs=r5 for two cycles
        ex_ld_pending = 1'b1; ex_ld_reg = 3'd5;
        drive(1'b1, 16'h0500, 16'h0060, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("ld_in_ready%0d", i), 32'(in_bus.in_ready), 32'd0);
            tick();
            chk($sformatf("ld_valid%0d", i), 32'(out_bus.out_valid), 32'd0);
        end
        chk("ld_stall_cnt", 32'(stall_cnt), 32'(STALL0 + 16'd2));
        ex_ld_pending = 1'b0;
        #1;
        chk("ld_release_ready", 32'(in_bus.in_ready), 32'd1);
        tick();
        chk("ld_valid_after", 32'(out_bus.out_valid), 32'd1);
        chk("ld_rs", 32'(out_bus.out_rs_data), 32'hA005);

        // backpressure hold for three cycles, then flush
        drive(1'b1, 16'h0100, 16'h0070, 1'b0, 2'd0, 1'b0);
        out_bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_in_ready%0d", i), 32'(in_bus.in_ready), 32'd0);
            tick();
            chk($sformatf("bp_valid%0d", i), 32'(out_bus.out_valid), 32'd1);
            chk($sformatf("bp_instr%0d", i), 32'(out_bus.out_instr), 32'h0500);
            chk($sformatf("bp_pc%0d", i), 32'(out_bus.out_pc), 32'h0060);
        end
        flush = 1'b1;
        #1;
        chk("fl_in_ready", 32'(in_bus.in_ready), 32'd0);
        tick();
        chk("fl_valid", 32'(out_bus.out_valid), 32'd0);
        flush = 1'b0;
        out_bus.out_ready = 1'b1;
        #1;
        chk("fl_after_ready", 32'(in_bus.in_ready), 32'd1);
        tick();
        chk("fl_after_valid", 32'(out_bus.out_valid), 32'd1);
        chk("fl_after_instr", 32'(out_bus.out_instr), 32'h0100);
        chk("bp_stall_cnt", 32'(stall_cnt), 32'(STALL0 + 16'd2));

        // flush blocks accept but the regfile write still lands
        drive(1'b1, 16'h0700, 16'h0078, 1'b0, 2'd0, 1'b0);
        flush = 1'b1; wb_en = 1'b1; wb_sel = 3'd6; wb_data = 16'h6666;
        #1;
        chk("flwb_in_ready", 32'(in_bus.in_ready), 32'd0);
        tick();
        chk("flwb_valid", 32'(out_bus.out_valid), 32'd0);
        flush = 1'b0; wb_en = 1'b0;
        drive(1'b1, 16'h0600, 16'h0080, 1'b0, 2'd0, 1'b0);
        tick();
        chk("flwb_rs", 32'(out_bus.out_rs_data), 32'h6666);
        chk("flwb_pc", 32'(out_bus.out_pc), 32'h0080);
        chk("flwb_stall_cnt", 32'(stall_cnt), 32'(STALL0 + 16'd2));

        // asynchronous reset while ID/EX is valid
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(out_bus.out_valid), 32'd0);
        chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("arst_rs", 32'(out_bus.out_rs_data), 32'd0);
        chk("arst_instr", 32'(out_bus.out_instr), 32'd0);
        chk("arst_in_ready", 32'(in_bus.in_ready), 32'd1);
        tick();
        rst = 1'b1;
        drive(1'b1, 16'h0640, 16'h0090, 1'b0, 2'd0, 1'b0);
        tick();
        chk("post_rst_valid", 32'(out_bus.out_valid), 32'd1);
        chk("post_rst_rs", 32'(out_bus.out_rs_data), 32'd0);
        chk("post_rst_rt", 32'(out_bus.out_rt_data), 32'd0);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
